de1_soc_hps_master_rx_byte_fifo: RTL and testbench

- Byte-stream FIFO directly downstream of the HPS-master Avalon-ST timing adapter, feeding the bytes-to-packets converter.
- The upstream byte source cannot be backpressured, so this block absorbs downstream stalls.
- It flags and counts bytes lost when full and exposes fill status for debug CSRs.
- Avalon-ST ready/valid on both sides, ready latency 0.

---
 rtl/de1_soc_hps_master_rx_byte_fifo_if.sv | 12 +
 rtl/de1_soc_hps_master_rx_byte_fifo.sv | 126 ++++++++++++
 tb/tb_de1_soc_hps_master_rx_byte_fifo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/de1_soc_hps_master_rx_byte_fifo_if.sv
// Byte-stream ready/valid channel (ready latency 0) used on both sides of the HPS-master RX byte FIFO.
// master drives valid/data and samples ready; slave samples valid/data and drives ready.
interface de1_soc_hps_master_rx_byte_fifo_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/de1_soc_hps_master_rx_byte_fifo.sv
// RX byte FIFO behind the HPS-master timing adapter: 1-cycle in-to-out latency, registered show-ahead head;
// upstream cannot stall, so bytes arriving while full are dropped and flagged (HPS_MASTER_RX_DROP_CNT_EN adds drop_count).
module de1_soc_hps_master_rx_byte_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 48
) (
    input  logic                                  clk,
    input  logic                                  reset,
    de1_soc_hps_master_rx_byte_fifo_if.slave      in_st,
    de1_soc_hps_master_rx_byte_fifo_if.master     out_st,
    output logic [$clog2(DEPTH):0]                fill_level,
    output logic                                  almost_full,
    output logic                                  overflow,
    input  logic                                  overflow_clr
`ifdef HPS_MASTER_RX_DROP_CNT_EN
    ,
    output logic [15:0]                           drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              overflow_q, overflow_d;

    logic wr_en;
    logic rd_en;
    logic drop;

    assign wr_en = in_st.valid & in_ready_q;
    assign rd_en = out_valid_q & out_st.ready;
    assign drop  = in_st.valid & ~in_ready_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d    = rd_ptr_q + PTR_W'(rd_en);
        count_d     = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        in_ready_d  = (count_d != CNT_W'(DEPTH));
        out_valid_d = (count_d != '0);
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;

        // Next head sits at the advanced read pointer; if that slot is being
        // written this very edge the queue holds exactly one byte, so bypass it.
        if (count_d != '0) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                out_data_d = in_st.data;
            end else begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_st.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef HPS_MASTER_RX_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    // A clear that coincides with a drop leaves that drop counted.
    always_comb begin
        drop_count_d = drop_count_q;
        if (overflow_clr) begin
            drop_count_d = {15'd0, drop};
        end else if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign in_st.ready  = in_ready_q;
    assign out_st.valid = out_valid_q;
    assign out_st.data  = out_data_q;
    assign fill_level   = count_q;
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_de1_soc_hps_master_rx_byte_fifo.sv
// Scoreboard bench for the HPS-master RX byte FIFO: a queue model tracks contents, flags and fill level every cycle.
module tb_de1_soc_hps_master_rx_byte_fifo;

    localparam int DEPTH = 64;
    localparam int AF    = 48;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [6:0] fill_level;
    logic       almost_full;
    logic       overflow;
`ifdef HPS_MASTER_RX_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    de1_soc_hps_master_rx_byte_fifo_if #(.DATA_W(8)) in_if ();
    de1_soc_hps_master_rx_byte_fifo_if #(.DATA_W(8)) out_if ();

    de1_soc_hps_master_rx_byte_fifo #(
        .DATA_W    (8),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_st        (in_if),
        .out_st       (out_if),
        .fill_level   (fill_level),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef HPS_MASTER_RX_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model, advanced on the falling edge from the inputs that the
    // next rising edge will see.
    logic [7:0] sb_q[$];
    logic       ov_m = 1'b0;
    int         dc_m = 0;

    always @(negedge clk) begin
        int  occ;
        logic drop;
        if (reset) begin
            sb_q.delete();
            ov_m = 1'b0;
            dc_m = 0;
        end else begin
            occ = sb_q.size();
            chk("fill_level", 32'(fill_level), 32'(occ));
            chk("in_ready", 32'(in_if.ready), 32'(occ != DEPTH));
            chk("out_valid", 32'(out_if.valid), 32'(occ != 0));
            chk("almost_full", 32'(almost_full), 32'(occ >= AF));
            chk("overflow", 32'(overflow), 32'(ov_m));
`ifdef HPS_MASTER_RX_DROP_CNT_EN
            chk("drop_count", 32'(drop_count), 32'(dc_m));
`endif
            if (occ != 0) chk("out_data", 32'(out_if.data), 32'(sb_q[0]));

            drop = in_if.valid && (occ == DEPTH);
            if (occ != 0 && out_if.ready) void'(sb_q.pop_front());
            if (in_if.valid && occ != DEPTH) sb_q.push_back(in_if.data);
            if (drop) ov_m = 1'b1;
            else if (overflow_clr) ov_m = 1'b0;
            if (overflow_clr) dc_m = drop ? 1 : 0;
            else if (drop && dc_m != 65535) dc_m++;
        end
    end

    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
        in_if.valid  = iv;
        in_if.data   = d;
        out_if.ready = ordy;
        overflow_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        in_if.valid  = 1'b0;
        in_if.data   = 8'h00;
        out_if.ready = 1'b0;

        #1 reset = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_if.ready), 0);
        chk("rst_out_valid", 32'(out_if.valid), 0);
        chk("rst_out_data", 32'(out_if.data), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_if.ready), 1);

        // Fill without draining
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == AF - 2) chk("af_before_48", 32'(almost_full), 0);
            if (i == AF - 1) chk("af_at_48", 32'(almost_full), 1);
        end
        chk("full_fill", 32'(fill_level), 64);
        chk("full_in_ready", 32'(in_if.ready), 0);

        // Overflow: three dropped bytes
        for (int i = 0; i < 3; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_fill", 32'(fill_level), 64);
`ifdef HPS_MASTER_RX_DROP_CNT_EN
        chk("ovf_drop_cnt", 32'(drop_count), 3);
`endif

        // Full with simultaneous read: write refused, next write accepted
        step(1'b1, 8'hB0, 1'b1, 1'b0);
        chk("full_rd_fill", 32'(fill_level), 63);
        chk("full_rd_in_ready", 32'(in_if.ready), 1);
        step(1'b1, 8'hB1, 1'b0, 1'b0);
        chk("next_wr_fill", 32'(fill_level), 64);

        // Clear, then drop coinciding with clear (set wins)
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 0);
        step(1'b1, 8'hC0, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 1);
`ifdef HPS_MASTER_RX_DROP_CNT_EN
        chk("drop_cnt_clr_wins1", 32'(drop_count), 1);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr2", 32'(overflow), 0);

        // Drain: expect 0x01..0x3F then 0xB1
        chk("drain_head", 32'(out_if.data), 32'h01);
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained_fill", 32'(fill_level), 0);
        chk("drained_valid", 32'(out_if.valid), 0);

        // Streaming at one byte per clock
        step(1'b1, 8'h10, 1'b1, 1'b0);
        chk("stream_first_valid", 32'(out_if.valid), 1);
        chk("stream_first_data", 32'(out_if.data), 32'h10);
        for (int i = 1; i < 50; i++) step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
        chk("stream_fill", 32'(fill_level), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Random stalls
        sent = 0;
        while (sent < 10000) begin
            logic iv;
            iv = 1'($urandom_range(1));
            step(iv, 8'($urandom), 1'($urandom_range(3) != 0), 1'b0);
            if (iv) sent++;
        end
        chk("rand_no_ovf", 32'(overflow), 0);
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-stream at fill level 20
        for (int i = 0; i < 20; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        chk("pre_rst_fill", 32'(fill_level), 20);
        in_if.valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_if.valid), 0);
        chk("async_rst_fill", 32'(fill_level), 0);
        chk("async_rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("post_rst_first", 32'(out_if.data), 32'h55);
        step(1'b1, 8'h56, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("end_fill", 32'(fill_level), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
